// File: rtl/lab3_mem_line_mem_responder.sv
// lab3_mem_line_mem_responder: 16B-line test memory answering memreq with in-order, fixed-latency memresp
module lab3_mem_line_mem_responder #(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 1,
  parameter int p_depth     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [174:0] memreq_msg,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  output logic [144:0] memresp_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy
);
  localparam int iw = $clog2(p_num_lines);
  localparam int pw = $clog2(p_depth);
  localparam int cw = pw + 1;
  localparam int aw = $clog2(p_latency + 1);
  logic [127:0]  line [p_num_lines];
  logic [2:0]    b_type [p_depth];
  logic [7:0]    b_opq  [p_depth];
  logic [127:0]  b_data [p_depth];
  logic [aw-1:0] age    [p_depth];
  logic [pw-1:0] head, tail;
  logic [cw-1:0] cnt;
  logic [2:0]    req_type;
  logic [iw-1:0] idx;
  logic          is_wr, enq, deq, unused_bits;
  assign req_type    = memreq_msg[174:172];
  assign idx         = memreq_msg[132+4 +: iw];
  assign is_wr       = req_type == 3'd1 || req_type == 3'd2;
  assign unused_bits = ^memreq_msg;
  assign memreq_rdy  = !reset && cnt < cw'(p_depth);
  assign memresp_val = !reset && cnt != '0 && age[head] == aw'(p_latency);
  assign memresp_msg = {b_type[head], b_opq[head], 2'b0, 4'b0, b_data[head]};
  assign enq = memreq_val && memreq_rdy;
  assign deq = memresp_val && memresp_rdy;
  always_ff @(posedge clk)
    if (enq && is_wr) line[idx] <= memreq_msg[127:0];
  // an entry's age already counts its accept cycle, so a new entry enters at 1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      head <= '0;
      tail <= '0;
      for (int i = 0; i < p_depth; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < p_depth; i++)
        age[i] <= age[i] == aw'(p_latency) ? age[i] : age[i] + 1'b1;
      if (enq) begin
        b_type[tail] <= req_type;
        b_opq[tail]  <= memreq_msg[171:164];
        b_data[tail] <= is_wr ? 128'b0 : line[idx];
        age[tail]    <= aw'(1);
        tail         <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      cnt <= cnt + cw'(enq) - cw'(deq);
    end
  end
endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// tb_lab3_mem_line_mem_responder: random traffic against a queue-and-array reference model
module tb_lab3_mem_line_mem_responder;
  localparam int L = 1, D = 4, N = 256;
  logic         clk = 1'b0;
  logic         reset;
  logic [174:0] memreq_msg;
  logic         memreq_val, memreq_rdy;
  logic [144:0] memresp_msg;
  logic         memresp_val, memresp_rdy;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [127:0] ref_mem [N];
  logic [144:0] q_msg [$];
  int           q_t   [$];

  lab3_mem_line_mem_responder #(.p_num_lines(N), .p_latency(L), .p_depth(D)) dut (
    .clk(clk), .reset(reset),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [144:0] got, input logic [144:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [174:0] mk(input logic [2:0] t, input logic [7:0] o,
                                      input logic [31:0] a, input logic [127:0] d);
    return {t, o, a, 4'($urandom), d};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one clock: drive, check outputs against the model, then advance the model at the edge
  task automatic step(input logic r, input logic v, input logic [174:0] m, input logic rr);
    logic exp_rdy, exp_val;
    logic [2:0] t;
    int i;
    reset = r; memreq_val = v; memreq_msg = m; memresp_rdy = rr;
    #1;
    exp_rdy = !r && q_msg.size() < D;
    exp_val = !r && q_msg.size() > 0 && cyc >= q_t[0] + L;
    chk("memreq_rdy", 145'(memreq_rdy), 145'(exp_rdy));
    chk("memresp_val", 145'(memresp_val), 145'(exp_val));
    if (exp_val) chk("memresp_msg", memresp_msg, q_msg[0]);
    @(posedge clk);
    if (r) begin
      q_msg.delete();
      q_t.delete();
    end else begin
      if (exp_val && rr) begin
        void'(q_msg.pop_front());
        void'(q_t.pop_front());
      end
      if (v && exp_rdy) begin
        t = m[174:172];
        i = int'(m[132+4 +: 8]);
        if (t == 3'd1 || t == 3'd2) begin
          q_msg.push_back({t, m[171:164], 6'b0, 128'b0});
          ref_mem[i] = m[127:0];
        end else
          q_msg.push_back({t, m[171:164], 6'b0, ref_mem[i]});
        q_t.push_back(cyc);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rand_phase(input int n, input int p_val, input int p_rr, input int p_rst);
    logic [2:0]  t;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      t = $urandom_range(0, 9) < 4 ? 3'd0 : $urandom_range(0, 9) < 7 ? 3'd1
        : $urandom_range(0, 1) == 0 ? 3'd2 : 3'($urandom_range(3, 7));
      a = {20'($urandom), 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom)};
      step($urandom_range(0, 199) < p_rst, $urandom_range(0, 99) < p_val,
           mk(t, 8'($urandom), a, rnd128()), $urandom_range(0, 99) < p_rr);
    end
  endtask

  initial begin
    reset = 1'b1; memreq_val = 1'b0; memreq_msg = '0; memresp_rdy = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, '0, 1'b1);
    for (int k = 0; k < N; k++)
      step(1'b0, 1'b1, mk(3'd2, 8'(k), {20'($urandom), 8'(k), 4'($urandom)}, rnd128()), 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, mk(3'd1, 8'h05, 32'h0000_1000, 128'hDEADBEEF_00000001_00000002_00000003), 1'b1);
    step(1'b0, 1'b1, mk(3'd0, 8'h06, 32'h0000_1008, '0), 1'b1);
    step(1'b0, 1'b1, mk(3'd1, 8'h07, 32'h0000_0010, 128'h1234), 1'b1);
    step(1'b0, 1'b1, mk(3'd0, 8'h08, 32'h0000_1010, '0), 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, mk(3'd0, 8'(k), 32'(k) << 4, '0), 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, mk(3'd0, 8'(k), 32'(k) << 4, '0), 1'b0);
    step(1'b0, 1'b1, mk(3'd0, 8'h66, 32'h20, '0), 1'b1);
    step(1'b0, 1'b1, mk(3'd0, 8'h67, 32'h30, '0), 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, mk(3'd1, 8'(k), 32'(k) << 4, rnd128()), 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, mk(3'd0, 8'(k), 32'(k) << 4, '0), 1'b1);
    rand_phase(800, 80, 100, 1);
    rand_phase(800, 70, 50, 1);
    rand_phase(800, 60, 10, 1);
    rand_phase(400, 90, 90, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
